// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: buttons, live counter values and load/display outputs of the clock setter
interface clock_set_ctrl_if;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_dec;
    logic [5:0]  cur_sec;
    logic [5:0]  cur_min;
    logic [4:0]  cur_hour;
    logic [4:0]  cur_day;
    logic [3:0]  cur_mont;
    logic [12:0] cur_year;
    logic        set_mode;
    logic [2:0]  edit_field;
    logic        ld_en;
    logic [2:0]  ld_sel;
    logic [12:0] ld_val;
    logic [12:0] shadow_val;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        output cur_sec, cur_min, cur_hour, cur_day, cur_mont, cur_year,
        input  set_mode, edit_field, ld_en, ld_sel, ld_val, shadow_val
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        input  cur_sec, cur_min, cur_hour, cur_day, cur_mont, cur_year,
        output set_mode, edit_field, ld_en, ld_sel, ld_val, shadow_val
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven editor that snapshots the clock, edits shadows and reloads the counters
module clock_set_ctrl #(
    parameter int TIMEOUT  = 30,
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2099
) (
    input logic          clk_1Hz,
    input logic          rst_n,
    clock_set_ctrl_if.slave cs
);
    typedef enum logic [1:0] {RUN, EDIT, COMMIT} state_t;

    localparam int          IW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [12:0] YMIN = 13'(YEAR_MIN);
    localparam logic [12:0] YMAX = 13'(YEAR_MAX);

    state_t            state_q, state_d;
    logic [2:0]        field_q, field_d;
    logic [2:0]        idx_q, idx_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [2:0]        btn_q;
    logic [5:0][12:0]  sh_q, sh_d;
    logic [2:0]        edge_w;
    logic [4:0]        mdays;
    logic [12:0]       lo, hi, cur_v, inc_v, dec_v;

    function automatic logic [4:0] max_day(input logic [3:0] m, input logic [1:0] y);
        return (m == 4'd2) ? ((y == 2'd0) ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    // mode/inc/dec rising edges against last cycle's sampled buttons
    assign edge_w = {cs.btn_mode, cs.btn_inc, cs.btn_dec} & ~btn_q;

    // wrap limits and stepped values of the shadow currently selected by edit_field
    always_comb begin
        mdays = max_day(sh_q[4][3:0], sh_q[5][1:0]);
        lo    = (field_q == 3'd5) ? YMIN : (field_q >= 3'd3) ? 13'd1 : 13'd0;
        hi    = (field_q <= 3'd1) ? 13'd59 :
                (field_q == 3'd2) ? 13'd23 :
                (field_q == 3'd3) ? {8'd0, mdays} :
                (field_q == 3'd4) ? 13'd12 : YMAX;
        cur_v = sh_q[field_q];
        inc_v = (cur_v >= hi) ? lo : cur_v + 13'd1;
        dec_v = (cur_v <= lo) ? hi : cur_v - 13'd1;
    end

    // next-state logic: snapshot in RUN, edit and idle timeout in EDIT, six-step reload in COMMIT
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        sh_d    = sh_q;
        case (state_q)
            RUN: begin
                idle_d  = '0;
                idx_d   = '0;
                field_d = '0;
                if (edge_w[2]) begin
                    sh_d[0] = {7'd0, cs.cur_sec};
                    sh_d[1] = {7'd0, cs.cur_min};
                    sh_d[2] = {8'd0, cs.cur_hour};
                    sh_d[3] = {8'd0, cs.cur_day};
                    sh_d[4] = {9'd0, cs.cur_mont};
                    sh_d[5] = cs.cur_year;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (|edge_w) begin
                    idle_d = '0;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    idle_d  = '0;
                    field_d = '0;
                    state_d = RUN;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                if (edge_w[2]) begin
                    if (field_q == 3'd5) begin
                        state_d = COMMIT;
                        idx_d   = '0;
                        sh_d[3] = (sh_q[3] > {8'd0, mdays}) ? {8'd0, mdays} : sh_q[3];
                    end else begin
                        field_d = field_q + 3'd1;
                    end
                end else if (edge_w[1]) begin
                    sh_d[field_q] = inc_v;
                end else if (edge_w[0]) begin
                    sh_d[field_q] = dec_v;
                end
            end
            COMMIT: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) begin
                    state_d = RUN;
                    field_d = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // state and shadow registers; edge history resets high so held buttons give no edge
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            field_q <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            btn_q   <= '1;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            btn_q   <= {cs.btn_mode, cs.btn_inc, cs.btn_dec};
            sh_q    <= sh_d;
        end
    end

    assign cs.set_mode   = (state_q != RUN);
    assign cs.edit_field = field_q;
    assign cs.ld_en      = (state_q == COMMIT);
    assign cs.ld_sel     = (state_q == COMMIT) ? idx_q : 3'd0;
    assign cs.ld_val     = (state_q == COMMIT) ? sh_q[idx_q] : 13'd0;
    assign cs.shadow_val = (state_q == RUN) ? 13'd0 : sh_q[field_q];
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of snapshot, wrap, clamp, priority, timeout and reset behaviour
module tb_clock_set_ctrl;
    logic clk_1Hz = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;
    int   pulses;
    logic [12:0] exp_ld [6];

    clock_set_ctrl_if cs ();

    clock_set_ctrl #(.TIMEOUT(30), .YEAR_MIN(2000), .YEAR_MAX(2099)) dut (
        .clk_1Hz(clk_1Hz),
        .rst_n  (rst_n),
        .cs     (cs)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        cs.btn_mode = m;
        cs.btn_inc  = i;
        cs.btn_dec  = d;
        step();
        cs.btn_mode = 1'b0;
        cs.btn_inc  = 1'b0;
        cs.btn_dec  = 1'b0;
        step();
    endtask

    task automatic set_cur(input int s, input int mi, input int h, input int d, input int mo, input int y);
        cs.cur_sec  = 6'(s);
        cs.cur_min  = 6'(mi);
        cs.cur_hour = 5'(h);
        cs.cur_day  = 5'(d);
        cs.cur_mont = 4'(mo);
        cs.cur_year = 13'(y);
    endtask

    task automatic do_commit(input string tag);
        cs.btn_mode = 1'b1;
        step();
        cs.btn_mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check({tag, "_ld_en"}, cs.ld_en, 1);
            check({tag, "_ld_sel"}, cs.ld_sel, 13'(k));
            check({tag, "_ld_val"}, cs.ld_val, exp_ld[k]);
            step();
        end
        check({tag, "_done_ld_en"}, cs.ld_en, 0);
        check({tag, "_done_set_mode"}, cs.set_mode, 0);
    endtask

    task automatic session(input string tag);
        press(1, 0, 0);
        for (int k = 0; k < 5; k++) press(1, 0, 0);
        check({tag, "_field5"}, cs.edit_field, 5);
        do_commit(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        cs.btn_mode = 1'b1;
        cs.btn_inc  = 1'b0;
        cs.btn_dec  = 1'b0;
        set_cur(0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_set_mode", cs.set_mode, 0);
        check("rst_ld_en", cs.ld_en, 0);
        check("rst_ld_sel", cs.ld_sel, 0);
        check("rst_ld_val", cs.ld_val, 0);
        check("rst_edit_field", cs.edit_field, 0);
        check("rst_shadow_val", cs.shadow_val, 0);
        rst_n = 1'b1;
        step();
        step();
        check("held_mode_no_edge", cs.set_mode, 0);
        cs.btn_mode = 1'b0;
        step();
        step();

        set_cur(45, 30, 12, 15, 6, 2024);
        exp_ld = '{13'd45, 13'd30, 13'd12, 13'd15, 13'd6, 13'd2024};
        press(1, 0, 0);
        check("s1_set_mode", cs.set_mode, 1);
        check("s1_field0", cs.edit_field, 0);
        check("s1_shadow0", cs.shadow_val, 45);
        for (int k = 1; k < 6; k++) begin
            press(1, 0, 0);
            check("s1_field", cs.edit_field, 13'(k));
            check("s1_shadow", cs.shadow_val, exp_ld[k]);
        end
        do_commit("s1");

        set_cur(0, 59, 23, 1, 1, 2030);
        press(1, 0, 0);
        press(1, 0, 0);
        check("min_shadow", cs.shadow_val, 59);
        press(0, 1, 0);
        check("min_inc_wrap", cs.shadow_val, 0);
        press(0, 0, 1);
        check("min_dec_wrap", cs.shadow_val, 59);
        press(1, 0, 0);
        check("hour_shadow", cs.shadow_val, 23);
        press(0, 1, 0);
        check("hour_inc_wrap", cs.shadow_val, 0);
        press(0, 0, 1);
        check("hour_dec_wrap", cs.shadow_val, 23);
        press(0, 1, 1);
        check("inc_over_dec", cs.shadow_val, 0);
        cs.btn_dec = 1'b1;
        repeat (3) step();
        cs.btn_dec = 1'b0;
        step();
        check("held_dec_once", cs.shadow_val, 23);
        repeat (30) step();
        check("hour_abort", cs.set_mode, 0);

        set_cur(10, 20, 5, 10, 3, 2099);
        press(1, 0, 0);
        for (int k = 0; k < 5; k++) press(1, 0, 0);
        check("year_shadow", cs.shadow_val, 2099);
        press(0, 1, 0);
        check("year_inc_wrap", cs.shadow_val, 2000);
        press(0, 0, 1);
        check("year_dec_wrap", cs.shadow_val, 2099);
        press(0, 0, 1);
        check("year_dec", cs.shadow_val, 2098);
        repeat (30) step();
        check("year_abort", cs.set_mode, 0);

        set_cur(1, 2, 3, 4, 5, 2040);
        press(1, 0, 0);
        pulses = 0;
        repeat (28) begin
            step();
            pulses += int'(cs.ld_en);
        end
        check("timeout_not_yet", cs.set_mode, 1);
        step();
        pulses += int'(cs.ld_en);
        check("timeout_run", cs.set_mode, 0);
        check("timeout_no_loads", 13'(pulses), 0);
        check("timeout_shadow_val", cs.shadow_val, 0);

        set_cur(1, 2, 3, 31, 4, 2024);
        exp_ld = '{13'd1, 13'd2, 13'd3, 13'd30, 13'd4, 13'd2024};
        session("apr");
        set_cur(1, 2, 3, 31, 2, 2023);
        exp_ld = '{13'd1, 13'd2, 13'd3, 13'd28, 13'd2, 13'd2023};
        session("feb23");
        set_cur(1, 2, 3, 31, 2, 2024);
        exp_ld = '{13'd1, 13'd2, 13'd3, 13'd29, 13'd2, 13'd2024};
        session("feb24");

        set_cur(5, 30, 7, 8, 9, 2050);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 1, 0);
        check("prio_field", cs.edit_field, 2);
        check("prio_hour_shadow", cs.shadow_val, 7);
        repeat (3) press(1, 0, 0);
        cs.btn_mode = 1'b1;
        step();
        cs.btn_mode = 1'b0;
        check("mid_ld_val0", cs.ld_val, 5);
        step();
        check("prio_min_unchanged", cs.ld_val, 30);
        step();
        check("mid_ld_sel2", cs.ld_sel, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_set_mode", cs.set_mode, 0);
        check("mid_rst_ld_en", cs.ld_en, 0);
        check("mid_rst_ld_sel", cs.ld_sel, 0);
        check("mid_rst_ld_val", cs.ld_val, 0);
        check("mid_rst_edit_field", cs.edit_field, 0);
        check("mid_rst_shadow_val", cs.shadow_val, 0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            step();
            pulses += int'(cs.ld_en);
        end
        check("post_rst_no_loads", 13'(pulses), 0);
        check("post_rst_set_mode", cs.set_mode, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
